// File: rtl/memory_arbiter_if.sv
// memory_arbiter_if
// Bundles the request-side and RAM-side signals of the memory arbiter.
//   Request side : iREN/iaddr (instruction read), dREN/dWEN/daddr/dstore (data),
//                  ihit/iload, dhit/dload (completion pulses and load words)
//   RAM side     : ramREN/ramWEN/ramaddr/ramstore (strobes, word address, write
//                  data), ramload/ramready (read data, completion)
//   Status       : memerr (sticky watchdog flag)
// The slave modport is the arbiter's view; master is the requester/RAM model.
interface memory_arbiter_if;
  logic        iREN;
  logic [31:0] iaddr;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        ihit;
  logic [31:0] iload;
  logic        dhit;
  logic [31:0] dload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic        ramready;
  logic        memerr;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramready,
    output ihit, iload, dhit, dload, ramREN, ramWEN, ramaddr, ramstore, memerr
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramready,
    input  ihit, iload, dhit, dload, ramREN, ramWEN, ramaddr, ramstore, memerr
  );
endinterface

// File: rtl/memory_arbiter.sv
// memory_arbiter
// Serializes instruction reads and data reads/writes onto one single-ported
// RAM. Data requests win over instruction requests. Every accepted access ends
// with exactly one single-cycle ihit or dhit pulse and a registered load word.
// A watchdog aborts an access after TIMEOUT cycles, returning 32'hBAD1BAD1 for
// reads and setting the sticky memerr flag.
// Ports:
//   CLK - clock, all state changes on the rising edge
//   RST - synchronous active-high reset
//   bus - memory_arbiter_if.slave (request, RAM and status signals)
module memory_arbiter #(
  parameter int TIMEOUT = 16
) (
  input logic             CLK,
  input logic             RST,
  memory_arbiter_if.slave bus
);

  localparam int                 CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(TIMEOUT - 1);
  localparam logic [31:0]        ERR_WORD = 32'hBAD1BAD1;

  typedef enum logic [1:0] {IDLE, IACC, DACC, RESP} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ramREN_q, ramREN_d;
  logic               ramWEN_q, ramWEN_d;
  logic [31:0]        ramaddr_q, ramaddr_d;
  logic [31:0]        ramstore_q, ramstore_d;
  logic               ihit_q, ihit_d;
  logic               dhit_q, dhit_d;
  logic [31:0]        iload_q, iload_d;
  logic [31:0]        dload_q, dload_d;
  logic               memerr_q, memerr_d;

  // Byte-lane bits of the request addresses never reach the RAM.
  logic unusedAddrBits;
  assign unusedAddrBits = ^{bus.iaddr[1:0], bus.daddr[1:0]};

  // State and output registers; reset aborts any access without a hit.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      ramREN_q   <= 1'b0;
      ramWEN_q   <= 1'b0;
      ramaddr_q  <= '0;
      ramstore_q <= '0;
      ihit_q     <= 1'b0;
      dhit_q     <= 1'b0;
      iload_q    <= '0;
      dload_q    <= '0;
      memerr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ramREN_q   <= ramREN_d;
      ramWEN_q   <= ramWEN_d;
      ramaddr_q  <= ramaddr_d;
      ramstore_q <= ramstore_d;
      ihit_q     <= ihit_d;
      dhit_q     <= dhit_d;
      iload_q    <= iload_d;
      dload_q    <= dload_d;
      memerr_q   <= memerr_d;
    end
  end

  // Next-state logic: accept in IDLE, hold the latched access until the RAM
  // completes or the watchdog fires, then pulse the hit for one RESP cycle.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ramREN_d   = ramREN_q;
    ramWEN_d   = ramWEN_q;
    ramaddr_d  = ramaddr_q;
    ramstore_d = ramstore_q;
    ihit_d     = 1'b0;
    dhit_d     = 1'b0;
    iload_d    = iload_q;
    dload_d    = dload_q;
    memerr_d   = memerr_q;

    unique case (state_q)
      IDLE: begin
        ramREN_d = 1'b0;
        ramWEN_d = 1'b0;
        if (bus.dWEN || bus.dREN) begin
          // A write wins when both data strobes are raised together.
          state_d    = DACC;
          cnt_d      = '0;
          ramaddr_d  = {bus.daddr[31:2], 2'b00};
          ramWEN_d   = bus.dWEN;
          ramREN_d   = !bus.dWEN;
          ramstore_d = bus.dWEN ? bus.dstore : 32'h0;
        end else if (bus.iREN) begin
          state_d    = IACC;
          cnt_d      = '0;
          ramaddr_d  = {bus.iaddr[31:2], 2'b00};
          ramREN_d   = 1'b1;
          ramWEN_d   = 1'b0;
          ramstore_d = 32'h0;
        end
      end

      IACC, DACC: begin
        // Counter holds (cycles in state - 1), so LAST_CNT marks the final
        // permitted cycle; ramready there still counts as a real completion.
        if (bus.ramready || (cnt_q == LAST_CNT)) begin
          state_d  = RESP;
          ramREN_d = 1'b0;
          ramWEN_d = 1'b0;
          if (state_q == IACC) begin
            ihit_d  = 1'b1;
            iload_d = bus.ramready ? bus.ramload : ERR_WORD;
          end else begin
            dhit_d = 1'b1;
            if (!ramWEN_q) begin
              dload_d = bus.ramready ? bus.ramload : ERR_WORD;
            end
          end
          if (!bus.ramready) begin
            memerr_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.ramREN   = ramREN_q;
  assign bus.ramWEN   = ramWEN_q;
  assign bus.ramaddr  = ramaddr_q;
  assign bus.ramstore = ramstore_q;
  assign bus.ihit     = ihit_q;
  assign bus.dhit     = dhit_q;
  assign bus.iload    = iload_q;
  assign bus.dload    = dload_q;
  assign bus.memerr   = memerr_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter
// Directed and randomized checks of memory_arbiter with TIMEOUT=4. The
// reference model works per transaction: which requester is served, how many
// strobe cycles it lasts, and what each load register and memerr end up as.
module tb_memory_arbiter;

  localparam int          TIMEOUT  = 4;
  localparam logic [31:0] ERR_WORD = 32'hBAD1BAD1;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  int errors = 0;
  int checks = 0;

  logic [31:0] iloadExp  = 32'h0;
  logic [31:0] dloadExp  = 32'h0;
  logic        memerrExp = 1'b0;

  memory_arbiter_if bus();

  memory_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  // One comparison: counts it and reports a failure with tag and values.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Drives random junk on every request-side and RAM input.
  task automatic scrambleInputs();
    bus.iREN     = 1'($urandom);
    bus.dREN     = 1'($urandom);
    bus.dWEN     = 1'($urandom);
    bus.iaddr    = $urandom;
    bus.daddr    = $urandom;
    bus.dstore   = $urandom;
    bus.ramload  = $urandom;
  endtask

  // One transaction starting in an IDLE cycle. readyAt is the strobe cycle
  // (1..TIMEOUT) in which the RAM answers; anything else means never.
  task automatic applyStimulus(input logic iReq, input logic dR, input logic dW,
                               input logic [31:0] ia, input logic [31:0] da,
                               input logic [31:0] ds, input int readyAt,
                               input logic [31:0] rdata);
    logic        servedData;
    logic        isWrite;
    logic        timedOut;
    logic [31:0] expAddr;
    logic [31:0] expStore;
    logic [31:0] loadVal;

    @(negedge CLK);
    checkOutput("idleREN",  32'(bus.ramREN), 32'(0));
    checkOutput("idleWEN",  32'(bus.ramWEN), 32'(0));
    checkOutput("idleIhit", 32'(bus.ihit),   32'(0));
    checkOutput("idleDhit", 32'(bus.dhit),   32'(0));
    bus.iREN     = iReq;
    bus.dREN     = dR;
    bus.dWEN     = dW;
    bus.iaddr    = ia;
    bus.daddr    = da;
    bus.dstore   = ds;
    bus.ramready = 1'b0;
    if (!(iReq || dR || dW)) return;

    servedData = dR || dW;
    isWrite    = dW;
    expAddr    = (servedData ? da : ia) & 32'hFFFF_FFFC;
    expStore   = isWrite ? ds : 32'h0;
    timedOut   = (readyAt < 1) || (readyAt > TIMEOUT);
    loadVal    = timedOut ? ERR_WORD : rdata;

    for (int k = 1; k <= TIMEOUT; k++) begin
      @(negedge CLK);
      checkOutput("accREN",   32'(bus.ramREN), 32'(!isWrite));
      checkOutput("accWEN",   32'(bus.ramWEN), 32'(isWrite));
      checkOutput("accAddr",  bus.ramaddr,     expAddr);
      checkOutput("accStore", bus.ramstore,    expStore);
      checkOutput("accIhit",  32'(bus.ihit),   32'(0));
      checkOutput("accDhit",  32'(bus.dhit),   32'(0));
      scrambleInputs();
      bus.ramready = (k == readyAt);
      if (k == readyAt) begin
        bus.ramload = rdata;
        break;
      end
    end

    if (timedOut) memerrExp = 1'b1;
    if (servedData && !isWrite) dloadExp = loadVal;
    if (!servedData) iloadExp = loadVal;

    @(negedge CLK);
    checkOutput("hitIhit",   32'(bus.ihit),   32'(!servedData));
    checkOutput("hitDhit",   32'(bus.dhit),   32'(servedData));
    checkOutput("hitREN",    32'(bus.ramREN), 32'(0));
    checkOutput("hitWEN",    32'(bus.ramWEN), 32'(0));
    checkOutput("hitIload",  bus.iload,       iloadExp);
    checkOutput("hitDload",  bus.dload,       dloadExp);
    checkOutput("hitMemerr", 32'(bus.memerr), 32'(memerrExp));
    // Requests and ramready during RESP must be ignored.
    scrambleInputs();
    bus.ramready = 1'($urandom);
  endtask

  initial begin
    bus.iREN     = 1'b0;
    bus.dREN     = 1'b0;
    bus.dWEN     = 1'b0;
    bus.iaddr    = 32'h0;
    bus.daddr    = 32'h0;
    bus.dstore   = 32'h0;
    bus.ramload  = 32'h0;
    bus.ramready = 1'b0;

    repeat (2) @(negedge CLK);
    checkOutput("rstREN",    32'(bus.ramREN), 32'(0));
    checkOutput("rstWEN",    32'(bus.ramWEN), 32'(0));
    checkOutput("rstAddr",   bus.ramaddr,     32'h0);
    checkOutput("rstIhit",   32'(bus.ihit),   32'(0));
    checkOutput("rstDhit",   32'(bus.dhit),   32'(0));
    checkOutput("rstMemerr", 32'(bus.memerr), 32'(0));
    RST = 1'b0;

    // Instruction read, RAM answers in strobe cycle 3.
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h104, 32'h0, 32'h0, 3, 32'h8C220004);
    // Data beats instruction; the instruction follows right after.
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 32'h2002, 32'h0, 1, 32'h1234);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h208, 32'h0, 32'h0, 2, 32'h2402000A);
    // Write wins over read when both strobes are high.
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h0, 32'h3000, 32'hDEADBEEF, 2, 32'h55AA55AA);
    // Ready in the last permitted cycle is a normal completion.
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 32'h4008, 32'h0, TIMEOUT, 32'hCAFEF00D);

    // Reset in the second cycle of a data read.
    @(negedge CLK);
    bus.iREN     = 1'b0;
    bus.dREN     = 1'b1;
    bus.dWEN     = 1'b0;
    bus.daddr    = 32'h5554;
    bus.ramready = 1'b0;
    @(negedge CLK);
    checkOutput("preRstREN", 32'(bus.ramREN), 32'(1));
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    iloadExp  = 32'h0;
    dloadExp  = 32'h0;
    memerrExp = 1'b0;
    checkOutput("midRstREN",    32'(bus.ramREN), 32'(0));
    checkOutput("midRstWEN",    32'(bus.ramWEN), 32'(0));
    checkOutput("midRstAddr",   bus.ramaddr,     32'h0);
    checkOutput("midRstStore",  bus.ramstore,    32'h0);
    checkOutput("midRstIhit",   32'(bus.ihit),   32'(0));
    checkOutput("midRstDhit",   32'(bus.dhit),   32'(0));
    checkOutput("midRstIload",  bus.iload,       iloadExp);
    checkOutput("midRstDload",  bus.dload,       dloadExp);
    checkOutput("midRstMemerr", 32'(bus.memerr), 32'(0));
    @(negedge CLK);
    checkOutput("reAccREN",  32'(bus.ramREN), 32'(1));
    checkOutput("reAccAddr", bus.ramaddr,     32'h5554);
    bus.ramready = 1'b1;
    bus.ramload  = 32'h600DF00D;
    @(negedge CLK);
    dloadExp = 32'h600DF00D;
    checkOutput("reAccDhit",  32'(bus.dhit), 32'(1));
    checkOutput("reAccIhit",  32'(bus.ihit), 32'(0));
    checkOutput("reAccDload", bus.dload,     dloadExp);
    bus.dREN     = 1'b0;
    bus.ramready = 1'b0;

    // Watchdog: RAM never answers.
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 32'h7000, 32'h0, 0, 32'h0);
    // memerr stays set across a later normal access.
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h44, 32'h0, 32'h0, 1, 32'h01234567);

    // Random traffic, including idle slots and timeouts.
    for (int n = 0; n < 150; n++) begin
      applyStimulus(1'($urandom), 1'($urandom), 1'($urandom), $urandom, $urandom,
                    $urandom, int'($urandom_range(0, TIMEOUT)), $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/memory_arbiter.md
# memory_arbiter

Responder side of the datapath memory request protocol. It accepts the always-on instruction read and the gated data read/write strobes, and serializes them onto a single-ported RAM interface. Data requests take priority over instruction requests. Each completed access returns exactly one single-cycle `ihit`/`dhit` pulse with registered load data. It sits between the request unit/datapath and the RAM model; a watchdog aborts any RAM access that never completes.

## Interface
- `TIMEOUT`, default 16: maximum cycles a RAM access may stay outstanding before abort (≥ 2).
- `CLK` in 1: system clock; all state updates on the rising edge.
- `RST` in 1: synchronous, active-high reset.
- `iREN` in 1: instruction read request.
- `iaddr` in 32: instruction byte address.
- `dREN` in 1: data read request.
- `dWEN` in 1: data write request.
- `daddr` in 32: data byte address.
- `dstore` in 32: data write value.
- `ihit` out 1: one-cycle pulse; instruction access complete, `iload` valid.
- `iload` out 32: registered instruction word.
- `dhit` out 1: one-cycle pulse; data access complete, `dload` valid for reads.
- `dload` out 32: registered data read word.
- `ramREN` out 1: RAM read strobe.
- `ramWEN` out 1: RAM write strobe.
- `ramaddr` out 32: RAM word address, `{addr[31:2],2'b00}`.
- `ramstore` out 32: RAM write data.
- `ramload` in 32: RAM read data; valid when `ramready` is high.
- `ramready` in 1: RAM access complete this cycle.
- `memerr` out 1: sticky flag; set on any timeout.

## Operation
- States: IDLE, IACC, DACC, RESP.
- **IDLE** (all RAM strobes low):
  - If `dWEN|dREN`, go to DACC. Latch `daddr`, `dstore`, and op = write if `dWEN`, else read. `dWEN` wins when both are high.
  - Else if `iREN`, go to IACC and latch `iaddr`.
  - Else stay in IDLE.
- **DACC/IACC**:
  - `ramREN`/`ramWEN` are registered and held from the latched op. IACC always reads.
  - `ramaddr` and `ramstore` are held constant for the whole access. `ramstore` is 0 for reads.
  - The watchdog counter increments each cycle in the state.
- **Completion:** `ramready` high in DACC/IACC causes the following on the next edge:
  - go to RESP;
  - drop RAM strobes;
  - capture `ramload` into `dload` (data read) or `iload` (instruction); `dload` is unchanged on writes;
  - assert the matching hit for the RESP cycle only.
- **Timeout:** if the access reaches its TIMEOUT-th cycle with `ramready` still low, the next edge:
  - goes to RESP with the matching hit;
  - loads 32'hBAD1BAD1 into the target load register (if a read);
  - sets `memerr`.
- `ramready` in the TIMEOUT-th cycle counts as a normal completion.
- **RESP:** hit high for exactly one cycle, then IDLE unconditionally. Requests held during RESP are not sampled until the IDLE cycle.
- `ramready` in IDLE or RESP is ignored.
- Requests changing mid-access are ignored; the latched request completes.
- Counter width is `$clog2(TIMEOUT+1)`. It clears on entering DACC/IACC and never wraps.
- **RST high at any edge** (including mid-access) forces IDLE and clears:
  - outputs `ramREN`, `ramWEN`, `ihit`, `dhit`, `memerr` to 0;
  - `ramaddr`, `ramstore`, `iload`, `dload` to 0;
  - the counter to 0.
  - No hit is produced for the aborted access.
- `memerr` clears only on RST.

## Timing
- Request high in cycle 0 → RAM strobes high from cycle 1.
- `ramready` in cycle n (n ≥ 1) → hit high in cycle n+1 → IDLE in cycle n+2. The earliest next access has strobes high in cycle n+3.
- Minimum request-to-hit latency: 2 cycles. Maximum: TIMEOUT+1.
- Exactly one hit per accepted access, never both hits in the same cycle.
- The requester drops `dREN`/`dWEN` on the edge ending the `dhit` cycle. The arbiter does not resample until IDLE, so there is no double service.
- Instruction starvation is bounded: after `dhit` the data request drops and a pending `iREN` is taken on the next IDLE.

## Test plan
- **Instruction read:** `iREN`=1, `iaddr`=0x104, RAM returns 0x8C220004 with `ramready` in strobe cycle 3.
  - `ramaddr`=0x104 and `ramREN`=1 in cycles 1–3.
  - `ihit`=1 and `iload`=0x8C220004 in cycle 4.
  - `dhit` stays 0.
- **Data priority:** `iREN`=1, `dREN`=1, `daddr`=0x2002, zero-wait RAM returning 0x1234.
  - Data served first with `ramaddr`=0x2000; `dhit` in cycle 2 with `dload`=0x1234.
  - Data request drops; next instruction access strobes start cycle 4.
- **Write with both strobes high:** `dWEN`=`dREN`=1, `dstore`=0xDEADBEEF.
  - `ramWEN`=1, `ramREN`=0, `ramstore`=0xDEADBEEF.
  - `dhit` pulses once; `dload` unchanged.
- **Timeout:** TIMEOUT=4, `dREN`=1, `ramready` never asserted.
  - Strobes high for cycles 1–4.
  - `dhit` in cycle 5, `dload`=0xBAD1BAD1, `memerr`=1 and stays set.
- **Ready at limit:** TIMEOUT=4, `ramready` in strobe cycle 4 → normal completion with RAM data; `memerr` stays 0.
- **Reset mid-access:** RST in cycle 2 of a read.
  - Cycle 3: all outputs 0, state IDLE, no hit.
  - Request still held → new access strobes in cycle 4.
